// File: rtl/pmod_axi_master.sv
// AXI4 bus master behind the Pmod command decoder: buffers write beats in a small FIFO and
// issues INCR write bursts / single-beat reads. Macro PMOD_AXI_RESP_CHECK_EN flags non-OKAY responses in err.
module pmod_axi_master #(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              write_req_i,
  input  logic              write_bus_req_i,
  input  logic              read_req_i,
  input  logic [9:0]        len_i,
  input  logic [31:0]       address_i,
  input  logic [63:0]       wdata_i,
  output logic              busy_o,
  output logic [63:0]       rdata_o,
  output logic              rlast_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] axi_awaddr_o,
  output logic [7:0]        axi_awlen_o,
  output logic [2:0]        axi_awsize_o,
  output logic [1:0]        axi_awburst_o,
  output logic              axi_awvalid_o,
  input  logic              axi_awready_i,
  output logic [63:0]       axi_wdata_o,
  output logic [7:0]        axi_wstrb_o,
  output logic              axi_wlast_o,
  output logic              axi_wvalid_o,
  input  logic              axi_wready_i,
  input  logic [1:0]        axi_bresp_i,
  input  logic              axi_bvalid_i,
  output logic              axi_bready_o,
  output logic [ADDR_W-1:0] axi_araddr_o,
  output logic [7:0]        axi_arlen_o,
  output logic [2:0]        axi_arsize_o,
  output logic [1:0]        axi_arburst_o,
  output logic              axi_arvalid_o,
  input  logic              axi_arready_i,
  input  logic [63:0]       axi_rdata_i,
  input  logic [1:0]        axi_rresp_i,
  input  logic              axi_rlast_i,
  input  logic              axi_rvalid_i,
  output logic              axi_rready_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

  // Short codes (len[2:0] != 0) pick 1/2/4/8 bytes; otherwise whole 64-bit beats.
  function automatic logic [2:0] dec_size(input logic [9:0] len);
    if (len[2:0] == 3'b000)      dec_size = 3'd3;
    else if (len[2:1] == 2'b11)  dec_size = 3'd3;
    else if (len[2])             dec_size = 3'd2;
    else if (len[1])             dec_size = 3'd1;
    else                         dec_size = 3'd0;
  endfunction

  function automatic logic [7:0] dec_awlen(input logic [9:0] len);
    dec_awlen = (len[2:0] == 3'b000) ? {1'b0, len[9:3]} : 8'd0;
  endfunction

  function automatic logic [7:0] dec_wstrb(input logic [9:0] len, input logic [2:0] lane);
    logic [15:0] mask;
    case (dec_size(len))
      3'd0:    mask = 16'h0001;
      3'd1:    mask = 16'h0003;
      3'd2:    mask = 16'h000F;
      default: mask = 16'h00FF;
    endcase
    mask = mask << lane;
    dec_wstrb = (len[2:0] == 3'b000) ? 8'hFF : mask[7:0];
  endfunction

  wstate_e           wstate_q, wstate_d;
  rstate_e           rstate_q, rstate_d;
  logic [ADDR_W-1:0] awaddr_q, araddr_q;
  logic [7:0]        awlen_q, wstrb_q, issued_q;
  logic [2:0]        awsize_q, arsize_q;
  logic [8:0]        rx_cnt_q;
  logic              closed_q;
  logic [63:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic [63:0]       rdata_q;
  logic              rlast_q, err_q;

  logic       fifo_empty, fifo_full, push, pop, w_start, w_hs, w_done;
  logic       r_start, r_hs, bus_close, mismatch, resp_err, err_set;
  logic [8:0] rx_total, beats_ref;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CW'(FIFO_DEPTH));
  assign push       = write_req_i && !fifo_full;
  assign w_start    = (wstate_q == W_IDLE) && write_req_i;
  assign w_hs       = axi_wvalid_o && axi_wready_i;
  assign pop        = w_hs && !fifo_empty;
  assign w_done     = (wstate_q == W_RESP) && axi_bvalid_i;
  assign busy_o     = (wstate_q != W_IDLE) || (rstate_q != R_IDLE) || !fifo_empty;
  assign r_start    = (rstate_q == R_IDLE) && read_req_i && !busy_o;
  assign r_hs       = (rstate_q == R_DATA) && axi_rvalid_i;

  // Beat-count check at burst close; the closing pulse rides on the final write_req.
  assign bus_close = write_bus_req_i && (w_start || (wstate_q != W_IDLE));
  assign rx_total  = (w_start ? 9'd0 : rx_cnt_q) + {8'd0, write_req_i};
  assign beats_ref = {1'b0, (w_start ? dec_awlen(len_i) : awlen_q)} + 9'd1;
  assign mismatch  = bus_close && (rx_total != beats_ref);

`ifdef PMOD_AXI_RESP_CHECK_EN
  logic unused_in;
  assign resp_err  = (w_done && (axi_bresp_i != 2'b00)) || (r_hs && (axi_rresp_i != 2'b00));
  assign unused_in = axi_rlast_i;
`else
  logic unused_in;
  assign resp_err  = 1'b0;
  assign unused_in = ^{axi_rlast_i, axi_bresp_i, axi_rresp_i};
`endif

  assign err_set = (read_req_i && busy_o) || (write_req_i && fifo_full) || mismatch || resp_err;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wstate_q <= W_IDLE;
      rstate_q <= R_IDLE;
    end else begin
      wstate_q <= wstate_d;
      rstate_q <= rstate_d;
    end
  end

  always_comb begin
    wstate_d = wstate_q;
    case (wstate_q)
      W_IDLE:  if (write_req_i)              wstate_d = W_ADDR;
      W_ADDR:  if (axi_awready_i)            wstate_d = W_DATA;
      W_DATA:  if (w_hs && axi_wlast_o)      wstate_d = W_RESP;
      W_RESP:  if (axi_bvalid_i)             wstate_d = W_IDLE;
      default:                               wstate_d = W_IDLE;
    endcase
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (r_start)                  rstate_d = R_ADDR;
      R_ADDR:  if (axi_arready_i)            rstate_d = R_DATA;
      R_DATA:  if (axi_rvalid_i)             rstate_d = R_IDLE;
      default:                               rstate_d = R_IDLE;
    endcase
  end

  // Valids depend only on registered state, never on the ready inputs.
  always_comb begin
    axi_awvalid_o = (wstate_q == W_ADDR);
    axi_wvalid_o  = (wstate_q == W_DATA) && (!fifo_empty || closed_q);
    axi_wlast_o   = (wstate_q == W_DATA) && (issued_q == awlen_q);
    axi_wdata_o   = fifo_empty ? 64'd0 : fifo_mem[rd_ptr_q];
    axi_wstrb_o   = ((wstate_q == W_DATA) && !fifo_empty) ? wstrb_q : 8'd0;
    axi_bready_o  = (wstate_q == W_RESP);
    axi_arvalid_o = (rstate_q == R_ADDR);
    axi_rready_o  = (rstate_q == R_DATA);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      awaddr_q <= '0;
      awlen_q  <= '0;
      awsize_q <= '0;
      wstrb_q  <= '0;
      issued_q <= '0;
      rx_cnt_q <= '0;
      closed_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      araddr_q <= '0;
      arsize_q <= '0;
      rdata_q  <= '0;
      rlast_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (w_start) begin
        awaddr_q <= ADDR_W'(address_i);
        awlen_q  <= dec_awlen(len_i);
        awsize_q <= dec_size(len_i);
        wstrb_q  <= dec_wstrb(len_i, address_i[2:0]);
        issued_q <= '0;
        rx_cnt_q <= 9'd1;
      end else begin
        if (w_hs)
          issued_q <= issued_q + 8'd1;
        if (write_req_i && (wstate_q != W_IDLE) && (rx_cnt_q != '1))
          rx_cnt_q <= rx_cnt_q + 9'd1;
      end
      if (w_done)         closed_q <= 1'b0;
      else if (bus_close) closed_q <= 1'b1;
      // Beats beyond the burst length are discarded when the burst retires.
      if (w_done) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        case ({push, pop})
          2'b10:   cnt_q <= cnt_q + CW'(1);
          2'b01:   cnt_q <= cnt_q - CW'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
      if (r_start) begin
        araddr_q <= ADDR_W'(address_i);
        arsize_q <= dec_size(len_i);
      end
      if (r_hs) rdata_q <= axi_rdata_i;
      rlast_q <= r_hs;
      err_q   <= err_q | err_set;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= wdata_i;
  end

  assign axi_awaddr_o  = awaddr_q;
  assign axi_awlen_o   = awlen_q;
  assign axi_awsize_o  = awsize_q;
  assign axi_awburst_o = 2'b01;
  assign axi_araddr_o  = araddr_q;
  assign axi_arlen_o   = 8'd0;
  assign axi_arsize_o  = arsize_q;
  assign axi_arburst_o = 2'b01;
  assign rdata_o       = rdata_q;
  assign rlast_o       = rlast_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_pmod_axi_master.sv
// Directed bench for pmod_axi_master: the bench plays the AXI slave and logs every AW/W handshake.
module tb_pmod_axi_master;

`ifdef PMOD_AXI_RESP_CHECK_EN
  localparam logic EXP_RESP_ERR = 1'b1;
`else
  localparam logic EXP_RESP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, write_req, write_bus_req, read_req;
  logic [9:0]  len;
  logic [31:0] address;
  logic [63:0] wdata_in;
  logic        busy, rlast, err;
  logic [63:0] rdata;
  logic [31:0] axi_awaddr, axi_araddr;
  logic [7:0]  axi_awlen, axi_arlen, axi_wstrb;
  logic [2:0]  axi_awsize, axi_arsize;
  logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
  logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
  logic        axi_rlast, axi_rvalid, axi_rready;
  logic [63:0] axi_wdata, axi_rdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] wd_log [16];
  logic [7:0]  ws_log [16];
  logic        wl_log [16];
  logic [31:0] aw_addr_log [4];
  logic [7:0]  aw_len_log [4];
  logic [2:0]  aw_size_log [4];
  int          wcnt = 0;
  int          awcnt = 0;

  pmod_axi_master #(.ADDR_W(32), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .reset_i(reset),
    .write_req_i(write_req), .write_bus_req_i(write_bus_req), .read_req_i(read_req),
    .len_i(len), .address_i(address), .wdata_i(wdata_in),
    .busy_o(busy), .rdata_o(rdata), .rlast_o(rlast), .err_o(err),
    .axi_awaddr_o(axi_awaddr), .axi_awlen_o(axi_awlen), .axi_awsize_o(axi_awsize),
    .axi_awburst_o(axi_awburst), .axi_awvalid_o(axi_awvalid), .axi_awready_i(axi_awready),
    .axi_wdata_o(axi_wdata), .axi_wstrb_o(axi_wstrb), .axi_wlast_o(axi_wlast),
    .axi_wvalid_o(axi_wvalid), .axi_wready_i(axi_wready),
    .axi_bresp_i(axi_bresp), .axi_bvalid_i(axi_bvalid), .axi_bready_o(axi_bready),
    .axi_araddr_o(axi_araddr), .axi_arlen_o(axi_arlen), .axi_arsize_o(axi_arsize),
    .axi_arburst_o(axi_arburst), .axi_arvalid_o(axi_arvalid), .axi_arready_i(axi_arready),
    .axi_rdata_i(axi_rdata), .axi_rresp_i(axi_rresp), .axi_rlast_i(axi_rlast),
    .axi_rvalid_i(axi_rvalid), .axi_rready_o(axi_rready)
  );

  always #5 clk = ~clk;

  // Handshake logger; inputs only change 1 ns after the edge, so this sees settled values.
  always @(posedge clk) begin
    if (axi_wvalid && axi_wready && wcnt < 16) begin
      wd_log[wcnt] = axi_wdata;
      ws_log[wcnt] = axi_wstrb;
      wl_log[wcnt] = axi_wlast;
      wcnt = wcnt + 1;
    end
    if (axi_awvalid && axi_awready && awcnt < 4) begin
      aw_addr_log[awcnt] = axi_awaddr;
      aw_len_log[awcnt]  = axi_awlen;
      aw_size_log[awcnt] = axi_awsize;
      awcnt = awcnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    write_req = 0; write_bus_req = 0; read_req = 0;
    len = '0; address = '0; wdata_in = '0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 2'b00;
    axi_arready = 0; axi_rvalid = 0; axi_rdata = '0; axi_rresp = 2'b00; axi_rlast = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    wcnt = 0;
    awcnt = 0;
  endtask

  task automatic finish_write(input string name);
    for (int i = 0; i < 20 && !axi_bready; i++) tick();
    checks++;
    if (axi_bready !== 1'b1) begin errors++; $display("FAIL %s_bready_timeout got %b want 1", name, axi_bready); end
    axi_awready = 0; axi_wready = 0;
    axi_bvalid = 1;
    tick();
    axi_bvalid = 0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after_b got %b want 0", name, busy); end
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick();
    tick();
    checks++;
    if ({busy, rlast, err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, rlast, err}); end
    checks++;
    if ({axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready} !== 5'b0) begin
      errors++; $display("FAIL reset_valids got %b want 00000", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready});
    end
    checks++;
    if (rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++;
    if ({axi_awaddr, axi_awlen, axi_awsize, axi_araddr, axi_arlen, axi_arsize} !== '0) begin
      errors++; $display("FAIL reset_addr got aw %h/%h/%h ar %h/%h/%h want 0", axi_awaddr, axi_awlen, axi_awsize, axi_araddr, axi_arlen, axi_arsize);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_write4();
    do_reset();
    len = 10'h004; address = 32'h0000_1006; wdata_in = 64'h0123_4567_89AB_CDEF;
    write_req = 1; write_bus_req = 1;
    tick();
    write_req = 0; write_bus_req = 0;
    checks++;
    if ({axi_awvalid, busy} !== 2'b11) begin errors++; $display("FAIL w4_awvalid_busy got %b want 11", {axi_awvalid, busy}); end
    checks++;
    if (axi_awaddr !== 32'h0000_1006) begin errors++; $display("FAIL w4_awaddr got %h want 00001006", axi_awaddr); end
    checks++;
    if ({axi_awlen, axi_awsize, axi_awburst} !== {8'd0, 3'd2, 2'b01}) begin
      errors++; $display("FAIL w4_awlen_size got %h/%h/%h want 0/2/1", axi_awlen, axi_awsize, axi_awburst);
    end
    axi_awready = 1;
    tick();
    axi_awready = 0;
    checks++;
    if ({axi_wvalid, axi_wlast} !== 2'b11) begin errors++; $display("FAIL w4_wvalid_wlast got %b want 11", {axi_wvalid, axi_wlast}); end
    // 4 bytes at lane 6: lanes 6..7 lie inside the beat, the rest fall off the top.
    checks++;
    if (axi_wstrb !== 8'hC0) begin errors++; $display("FAIL w4_wstrb got %h want c0", axi_wstrb); end
    checks++;
    if (axi_wdata !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL w4_wdata got %h want 0123456789abcdef", axi_wdata); end
    axi_wready = 1;
    tick();
    axi_wready = 0;
    checks++;
    if ({axi_bready, axi_wvalid, busy} !== 3'b101) begin errors++; $display("FAIL w4_resp_phase got %b want 101", {axi_bready, axi_wvalid, busy}); end
    axi_bvalid = 1;
    tick();
    axi_bvalid = 0;
    checks++;
    if ({busy, err} !== 2'b00) begin errors++; $display("FAIL w4_done got busy/err %b want 00", {busy, err}); end
  endtask

  task automatic test_burst32();
    do_reset();
    len = 10'h018; address = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      wdata_in = {32'hB0B0_0000 + 32'(k), 32'hC0DE_0000 + 32'(k)};
      write_req = 1; write_bus_req = (k == 3);
      tick();
    end
    write_req = 0; write_bus_req = 0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if ({axi_awvalid, axi_wvalid} !== 2'b10) begin errors++; $display("FAIL b32_aw_hold got %b want 10", {axi_awvalid, axi_wvalid}); end
    checks++;
    if (axi_awaddr !== 32'h0000_2000) begin errors++; $display("FAIL b32_awaddr_hold got %h want 00002000", axi_awaddr); end
    axi_awready = 1;
    tick();
    axi_awready = 0;
    for (int i = 0; i < 40 && wcnt < 4; i++) begin
      axi_wready = (i % 2 == 1);
      tick();
    end
    axi_wready = 0;
    checks++;
    if (wcnt !== 4) begin errors++; $display("FAIL b32_beats got %0d want 4", wcnt); end
    checks++;
    if ({aw_len_log[0], aw_size_log[0]} !== {8'd3, 3'd3}) begin
      errors++; $display("FAIL b32_awlen_size got %h/%h want 3/3", aw_len_log[0], aw_size_log[0]);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({wd_log[k], ws_log[k], wl_log[k]} !== {32'hB0B0_0000 + 32'(k), 32'hC0DE_0000 + 32'(k), 8'hFF, (k == 3)}) begin
        errors++; $display("FAIL b32_beat%0d got %h/%h/%b want data %h%h strb ff last %b", k, wd_log[k], ws_log[k], wl_log[k],
                           32'hB0B0_0000 + 32'(k), 32'hC0DE_0000 + 32'(k), (k == 3));
      end
    end
    finish_write("b32");
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL b32_err got %b want 0", err); end
  endtask

  task automatic test_overflow();
    do_reset();
    len = 10'h020; address = 32'h0000_3000;
    for (int k = 0; k < 5; k++) begin
      wdata_in = {32'hF1F0_0000 + 32'(k), 32'(k)};
      write_req = 1; write_bus_req = (k == 4);
      tick();
      if (k == 3) begin
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL ovf_err_before_full got %b want 0", err); end
      end
    end
    write_req = 0; write_bus_req = 0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b want 1", err); end
    axi_awready = 1;
    tick();
    axi_awready = 0;
    axi_wready = 1;
    for (int i = 0; i < 20 && wcnt < 5; i++) tick();
    axi_wready = 0;
    checks++;
    if (wcnt !== 5) begin errors++; $display("FAIL ovf_beats got %0d want 5", wcnt); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({wd_log[k], ws_log[k], wl_log[k]} !== {32'hF1F0_0000 + 32'(k), 32'(k), 8'hFF, 1'b0}) begin
        errors++; $display("FAIL ovf_beat%0d got %h/%h/%b want %h%h/ff/0", k, wd_log[k], ws_log[k], wl_log[k], 32'hF1F0_0000 + 32'(k), 32'(k));
      end
    end
    checks++;
    if ({ws_log[4], wl_log[4]} !== {8'h00, 1'b1}) begin errors++; $display("FAIL ovf_dropped_beat got strb %h last %b want 00/1", ws_log[4], wl_log[4]); end
    finish_write("ovf");
  endtask

  task automatic test_mismatch();
    do_reset();
    len = 10'h008; address = 32'h0000_5000; wdata_in = 64'hDEAD_BEEF_0000_0001;
    write_req = 1; write_bus_req = 1;
    tick();
    write_req = 0; write_bus_req = 0;
    checks++;
    if ({err, axi_awlen} !== {1'b1, 8'd1}) begin errors++; $display("FAIL mm_err_awlen got %b/%h want 1/01", err, axi_awlen); end
    axi_awready = 1; axi_wready = 1;
    for (int i = 0; i < 20 && wcnt < 2; i++) tick();
    axi_awready = 0; axi_wready = 0;
    checks++;
    if (wcnt !== 2) begin errors++; $display("FAIL mm_beats got %0d want 2", wcnt); end
    checks++;
    if ({ws_log[0], wl_log[0], ws_log[1], wl_log[1]} !== {8'hFF, 1'b0, 8'h00, 1'b1}) begin
      errors++; $display("FAIL mm_strb_last got %h/%b %h/%b want ff/0 00/1", ws_log[0], wl_log[0], ws_log[1], wl_log[1]);
    end
    finish_write("mm");
  endtask

  task automatic test_read1();
    do_reset();
    len = 10'h001; address = 32'h0000_2003;
    read_req = 1;
    tick();
    read_req = 0;
    checks++;
    if ({axi_arvalid, busy} !== 2'b11) begin errors++; $display("FAIL rd_arvalid_busy got %b want 11", {axi_arvalid, busy}); end
    checks++;
    if ({axi_araddr, axi_arlen, axi_arsize, axi_arburst} !== {32'h0000_2003, 8'd0, 3'd0, 2'b01}) begin
      errors++; $display("FAIL rd_ar got %h/%h/%h/%h want 00002003/0/0/1", axi_araddr, axi_arlen, axi_arsize, axi_arburst);
    end
    axi_arready = 1;
    tick();
    axi_arready = 0;
    checks++;
    if ({axi_rready, axi_arvalid} !== 2'b10) begin errors++; $display("FAIL rd_rready got %b want 10", {axi_rready, axi_arvalid}); end
    axi_rvalid = 1; axi_rdata = 64'h1122_3344_5566_7788; axi_rlast = 1;
    tick();
    axi_rvalid = 0; axi_rdata = '0; axi_rlast = 0;
    checks++;
    if (rdata !== 64'h1122_3344_5566_7788) begin errors++; $display("FAIL rd_rdata got %h want 1122334455667788", rdata); end
    checks++;
    if ({rlast, busy} !== 2'b10) begin errors++; $display("FAIL rd_rlast_busy got %b want 10", {rlast, busy}); end
    tick();
    checks++;
    if (rlast !== 1'b0) begin errors++; $display("FAIL rd_rlast_pulse got %b want 0", rlast); end
    // A read arriving while a write is in flight is refused and flagged.
    len = 10'h007; address = 32'h0000_6000;
    write_req = 1; write_bus_req = 1;
    tick();
    write_req = 0; write_bus_req = 0;
    read_req = 1;
    tick();
    read_req = 0;
    checks++;
    if ({err, axi_arvalid} !== 2'b10) begin errors++; $display("FAIL rd_busy_refused got err/arvalid %b want 10", {err, axi_arvalid}); end
  endtask

  task automatic test_resp_err();
    do_reset();
    len = 10'h006; address = 32'h0000_3000; wdata_in = 64'h5555_AAAA_5555_AAAA;
    axi_awready = 1; axi_wready = 1;
    write_req = 1; write_bus_req = 1;
    tick();
    write_req = 0; write_bus_req = 0;
    for (int i = 0; i < 20 && !axi_bready; i++) tick();
    axi_awready = 0; axi_wready = 0;
    checks++;
    if ({wcnt, ws_log[0]} !== {32'd1, 8'hFF}) begin errors++; $display("FAIL resp_beat got cnt %0d strb %h want 1/ff", wcnt, ws_log[0]); end
    axi_bvalid = 1; axi_bresp = 2'b10;
    tick();
    axi_bvalid = 0; axi_bresp = 2'b00;
    checks++;
    if ({err, busy} !== {EXP_RESP_ERR, 1'b0}) begin errors++; $display("FAIL resp_err got err/busy %b want %b0", {err, busy}, EXP_RESP_ERR); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    len = 10'h018; address = 32'h0000_7000;
    for (int k = 0; k < 4; k++) begin
      wdata_in = 64'h7700_0000_0000_0000 + 64'(k);
      write_req = 1; write_bus_req = (k == 3);
      tick();
    end
    write_req = 0; write_bus_req = 0;
    axi_awready = 1; axi_wready = 1;
    for (int i = 0; i < 20 && wcnt < 2; i++) tick();
    reset = 1; axi_awready = 0; axi_wready = 0;
    tick();
    checks++;
    if (wcnt !== 2) begin errors++; $display("FAIL rm_beats_before_reset got %0d want 2", wcnt); end
    checks++;
    if ({busy, err, rlast, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready} !== 8'd0) begin
      errors++; $display("FAIL rm_ctrl got %b want 00000000", {busy, err, rlast, axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready});
    end
    checks++;
    if ({axi_awaddr, axi_awlen, axi_awsize, axi_wdata, axi_wstrb} !== '0) begin
      errors++; $display("FAIL rm_outputs got %h/%h/%h/%h/%h want 0", axi_awaddr, axi_awlen, axi_awsize, axi_wdata, axi_wstrb);
    end
    reset = 0;
    wcnt = 0; awcnt = 0;
    len = 10'h007; address = 32'h0000_4008; wdata_in = 64'hCAFE_F00D_1234_5678;
    axi_awready = 1; axi_wready = 1;
    write_req = 1; write_bus_req = 1;
    tick();
    write_req = 0; write_bus_req = 0;
    for (int i = 0; i < 20 && wcnt < 1; i++) tick();
    checks++;
    if ({wcnt, aw_addr_log[0]} !== {32'd1, 32'h0000_4008}) begin errors++; $display("FAIL rm_fresh_aw got cnt %0d addr %h want 1/00004008", wcnt, aw_addr_log[0]); end
    checks++;
    if ({wd_log[0], ws_log[0], wl_log[0]} !== {64'hCAFE_F00D_1234_5678, 8'hFF, 1'b1}) begin
      errors++; $display("FAIL rm_fresh_beat got %h/%h/%b want cafef00d12345678/ff/1", wd_log[0], ws_log[0], wl_log[0]);
    end
    finish_write("rm");
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rm_err got %b want 0", err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_write4();
    test_burst32();
    test_overflow();
    test_mismatch();
    test_read1();
    test_resp_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
